// File: rtl/mem_dev_pkg.sv
// Shared opcode/state encodings and default timing for the mem_ctrl device responder.
// Shared by mem_ctrl and the responder; optional illegal-command checking is gated by MEM_DEV_PROT_CHECK_EN.
package mem_dev_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_REFRESH   = 3'd5
  } mem_cmd_e;

  typedef enum logic [2:0] {
    MDS_IDLE     = 3'd0,
    MDS_ACT_WAIT = 3'd1,
    MDS_ACTIVE   = 3'd2,
    MDS_RD_LAT   = 3'd3,
    MDS_REF_WAIT = 3'd4
  } mem_dev_state_e;

  localparam int DEF_TRCD = 2;
  localparam int DEF_TCAS = 3;
  localparam int DEF_TRFC = 4;

  // NOP is always legal; reserved opcodes never match and so are always illegal.
  function automatic logic cmd_legal(mem_dev_state_e st, mem_cmd_e cmd);
    logic ok;
    ok = (cmd == CMD_NOP);
    case (st)
      MDS_IDLE:   ok = ok || (cmd == CMD_ACTIVATE) || (cmd == CMD_PRECHARGE) || (cmd == CMD_REFRESH);
      MDS_ACTIVE: ok = ok || (cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_PRECHARGE);
      default:    ok = ok;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_dev_responder_if.sv
// Command/status bundle between a mem_ctrl master and the device responder (DQ stays a plain inout).
interface mem_dev_responder_if #(
  parameter int RA_W = 4,
  parameter int CA_W = 12
);
  import mem_dev_pkg::*;

  logic            cs_n;
  logic [2:0]      command;
  logic [RA_W-1:0] RA;
  logic [CA_W-1:0] CA;
  logic            dq_oe;
  logic            row_open;
  logic [RA_W-1:0] open_row;
  logic            busy;
  logic            prot_err;

  modport master (
    output cs_n, command, RA, CA,
    input  dq_oe, row_open, open_row, busy, prot_err
  );

  modport slave (
    input  cs_n, command, RA, CA,
    output dq_oe, row_open, open_row, busy, prot_err
  );

endinterface

// File: rtl/mem_dev_array.sv
// Single-port word storage: synchronous write, asynchronous read, contents never reset.
module mem_dev_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/mem_dev_responder.sv
// Single-bank memory device responder: open-row FSM, CAS-latency read return, tri-state DQ.
// Define MEM_DEV_PROT_CHECK_EN to enable prot_err pulses and $error reports on illegal commands.
module mem_dev_responder
  import mem_dev_pkg::*;
#(
  parameter int RA_W   = 4,
  parameter int CA_W   = 12,
  parameter int DATA_W = 32,
  parameter int TRCD   = DEF_TRCD,
  parameter int TCAS   = DEF_TCAS,
  parameter int TRFC   = DEF_TRFC
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_dev_responder_if.slave  bus,
  inout  wire  [DATA_W-1:0]   DQ
);

  localparam logic [2:0] ST_IDLE     = 3'(MDS_IDLE);
  localparam logic [2:0] ST_ACT_WAIT = 3'(MDS_ACT_WAIT);
  localparam logic [2:0] ST_ACTIVE   = 3'(MDS_ACTIVE);
  localparam logic [2:0] ST_RD_LAT   = 3'(MDS_RD_LAT);
  localparam logic [2:0] ST_REF_WAIT = 3'(MDS_REF_WAIT);

  localparam int AW       = RA_W + CA_W;
  localparam int CNT_MAX0 = (TRCD > TCAS) ? TRCD : TCAS;
  localparam int CNT_MAX  = (CNT_MAX0 > TRFC) ? CNT_MAX0 : TRFC;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]        state_reg,    state_next;
  logic [CNT_W-1:0]  cnt_reg,      cnt_next;
  logic [RA_W-1:0]   open_row_reg, open_row_next;
  logic [CA_W-1:0]   ca_lat_reg,   ca_lat_next;
  logic              dq_oe_reg,    dq_oe_next;
  logic [DATA_W-1:0] rd_data_reg,  rd_data_next;

  logic              cmd_valid;
  mem_cmd_e          cmd;
  logic              wr_en;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd_valid = rst_n && !bus.cs_n;
  assign cmd       = mem_cmd_e'(bus.command);

  // Writes address the incoming column; otherwise the port serves the latched read column.
  assign mem_addr = wr_en ? {open_row_reg, bus.CA} : {open_row_reg, ca_lat_reg};

  mem_dev_array #(
    .ADDR_W (AW),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .addr  (mem_addr),
    .wdata (DQ),
    .rdata (mem_rdata)
  );

  // Wait states advance regardless of any command; illegal commands simply fall through.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    open_row_next = open_row_reg;
    ca_lat_next   = ca_lat_reg;
    dq_oe_next    = 1'b0;
    rd_data_next  = rd_data_reg;
    wr_en         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_ACTIVATE: begin
              open_row_next = bus.RA;
              cnt_next      = CNT_W'(TRCD - 1);
              state_next    = (TRCD <= 1) ? ST_ACTIVE : ST_ACT_WAIT;
            end
            CMD_REFRESH: begin
              cnt_next   = CNT_W'(TRFC - 1);
              state_next = (TRFC <= 1) ? ST_IDLE : ST_REF_WAIT;
            end
            default: state_next = ST_IDLE;
          endcase
        end
      end

      ST_ACT_WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_WRITE: wr_en = 1'b1;
            CMD_READ: begin
              ca_lat_next = bus.CA;
              cnt_next    = CNT_W'(TCAS - 1);
              state_next  = ST_RD_LAT;
            end
            CMD_PRECHARGE: state_next = ST_IDLE;
            default:       state_next = ST_ACTIVE;
          endcase
        end
      end

      ST_RD_LAT: begin
        if (cnt_reg == '0) begin
          dq_oe_next   = 1'b1;
          rd_data_next = mem_rdata;
          state_next   = ST_ACTIVE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_REF_WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      open_row_reg <= '0;
      ca_lat_reg   <= '0;
      dq_oe_reg    <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      open_row_reg <= open_row_next;
      ca_lat_reg   <= ca_lat_next;
      dq_oe_reg    <= dq_oe_next;
      rd_data_reg  <= rd_data_next;
    end
  end

`ifdef MEM_DEV_PROT_CHECK_EN
  logic illegal;
  logic prot_err_reg;

  assign illegal = cmd_valid && !cmd_legal(mem_dev_state_e'(state_reg), cmd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prot_err_reg <= 1'b0;
    end else begin
      prot_err_reg <= illegal;
      if (illegal) begin
        $error("%0t mem_dev_responder: illegal command %0d in state %0d",
               $time, bus.command, state_reg);
      end
    end
  end

  assign bus.prot_err = prot_err_reg;
`else
  assign bus.prot_err = 1'b0;
`endif

  assign bus.dq_oe    = dq_oe_reg;
  assign bus.open_row = open_row_reg;
  assign bus.row_open = (state_reg == ST_ACTIVE) || (state_reg == ST_RD_LAT) ||
                        (state_reg == ST_ACT_WAIT);
  assign bus.busy     = (state_reg == ST_ACT_WAIT) || (state_reg == ST_RD_LAT) ||
                        (state_reg == ST_REF_WAIT);

  assign DQ = dq_oe_reg ? rd_data_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_dev_responder.sv
// Scoreboard bench for mem_dev_responder: stimulus queues expected reads/pulses, a monitor checks them.
module tb_mem_dev_responder;
  import mem_dev_pkg::*;

  localparam int RA_W   = 4;
  localparam int CA_W   = 12;
  localparam int DATA_W = 32;
  localparam int TRCD   = 2;
  localparam int TCAS   = 3;
  localparam int TRFC   = 4;
`ifdef MEM_DEV_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire  [DATA_W-1:0] dq;
  logic              tb_dq_en = 1'b0;
  logic [DATA_W-1:0] tb_dq    = '0;
  assign dq = tb_dq_en ? tb_dq : {DATA_W{1'bz}};

  mem_dev_responder_if #(.RA_W(RA_W), .CA_W(CA_W)) bus ();

  mem_dev_responder #(
    .RA_W(RA_W), .CA_W(CA_W), .DATA_W(DATA_W),
    .TRCD(TRCD), .TCAS(TCAS), .TRFC(TRFC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .DQ    (dq)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                at_cyc;
    string             name;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      prot_q[$];
  int      cyc       = 0;
  int      last_edge = 0;
  int      checks    = 0;
  int      errors    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DQ drive and every prot_err pulse must match a queued expectation.
  always @(negedge clk) begin
    rd_exp_t e;
    int      pe;
    if (bus.dq_oe === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: dq_oe=1 at cycle %0d dq=%h, required no drive", cyc, dq);
      end else begin
        e = rd_q.pop_front();
        if (dq !== e.data || cyc != e.at_cyc) begin
          errors++;
          $display("FAIL %s: dq=%h at cycle %0d, required %h at cycle %0d",
                   e.name, dq, cyc, e.data, e.at_cyc);
        end else begin
          $display("read %s: dq=%h at cycle %0d ok", e.name, dq, cyc);
        end
      end
    end
    if (bus.prot_err === 1'b1) begin
      checks++;
      if (prot_q.size() == 0) begin
        errors++;
        $display("FAIL prot_unexpected: prot_err=1 at cycle %0d, required 0", cyc);
      end else begin
        pe = prot_q.pop_front();
        if (cyc != pe) begin
          errors++;
          $display("FAIL prot_timing: prot_err at cycle %0d, required cycle %0d", cyc, pe);
        end else begin
          $display("prot_err pulse at cycle %0d ok", cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end else begin
      $display("check %s: %h ok", name, got);
    end
  endtask

  // Drive one command for exactly one rising edge; returns 1ns after that edge.
  task automatic issue(input logic [2:0] c, input logic [RA_W-1:0] ra,
                       input logic [CA_W-1:0] ca, input logic [DATA_W-1:0] d,
                       input logic cs);
    @(negedge clk);
    bus.cs_n    = cs;
    bus.command = c;
    bus.RA      = ra;
    bus.CA      = ca;
    tb_dq       = d;
    tb_dq_en    = (c == CMD_WRITE);
    @(posedge clk);
    #1;
    last_edge   = cyc;
    bus.cs_n    = 1'b1;
    bus.command = CMD_NOP;
    tb_dq_en    = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) issue(CMD_NOP, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [CA_W-1:0] ca, input logic [DATA_W-1:0] d);
    issue(CMD_WRITE, '0, ca, d, 1'b0);
  endtask

  task automatic act(input logic [RA_W-1:0] ra);
    issue(CMD_ACTIVATE, ra, '0, '0, 1'b0);
  endtask

  task automatic rd_start(input logic [CA_W-1:0] ca, input logic [DATA_W-1:0] exp, input string name);
    issue(CMD_READ, '0, ca, '0, 1'b0);
    rd_q.push_back('{data: exp, at_cyc: last_edge + TCAS, name: name});
  endtask

  task automatic rd(input logic [CA_W-1:0] ca, input logic [DATA_W-1:0] exp, input string name);
    rd_start(ca, exp, name);
    nop(TCAS + 1);
  endtask

  task automatic bad(input logic [2:0] c, input logic [RA_W-1:0] ra,
                     input logic [CA_W-1:0] ca, input logic [DATA_W-1:0] d);
    issue(c, ra, ca, d, 1'b0);
    if (PROT_EN) prot_q.push_back(last_edge);
  endtask

  initial begin
    bus.cs_n    = 1'b1;
    bus.command = CMD_NOP;
    bus.RA      = '0;
    bus.CA      = '0;

    // Reset state
    nop(3);
    check("rst_dq_oe",    32'(bus.dq_oe),    32'd0);
    check("rst_row_open", 32'(bus.row_open), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_prot_err", 32'(bus.prot_err), 32'd0);
    check("rst_open_row", 32'(bus.open_row), 32'd0);
    rst_n = 1'b1;

    // Basic activate / write / read
    act(4'd1);
    check("act_busy",     32'(bus.busy),     32'd1);
    check("act_row_open", 32'(bus.row_open), 32'd1);
    check("act_open_row", 32'(bus.open_row), 32'd1);
    nop(1);
    check("active_busy",  32'(bus.busy),     32'd0);
    wr(12'h001, 32'hA5A5A5A5);
    rd(12'h001, 32'hA5A5A5A5, "rd_basic");
    check("post_rd_dq_oe", 32'(bus.dq_oe), 32'd0);

    // Write row 2, precharge, refresh, reopen and read back
    issue(CMD_PRECHARGE, '0, '0, '0, 1'b0);
    act(4'd2);
    nop(1);
    wr(12'h000, 32'hDEADBEEF);
    issue(CMD_PRECHARGE, '0, '0, '0, 1'b0);
    check("pre_row_open", 32'(bus.row_open), 32'd0);
    issue(CMD_REFRESH, '0, '0, '0, 1'b0);
    check("ref_busy",     32'(bus.busy),     32'd1);
    nop(TRFC - 1);
    check("ref_done_busy", 32'(bus.busy),    32'd0);
    nop(1);
    act(4'd2);
    nop(1);
    rd(12'h000, 32'hDEADBEEF, "rd_after_refresh");

    // READ in IDLE is illegal and must not drive DQ
    issue(CMD_PRECHARGE, '0, '0, '0, 1'b0);
    bad(CMD_READ, '0, 12'h001, '0);
    check("idle_rd_row_open", 32'(bus.row_open), 32'd0);
    check("idle_rd_busy",     32'(bus.busy),     32'd0);
    nop(TCAS + 1);
    check("idle_rd_dq_oe",    32'(bus.dq_oe),    32'd0);

    // WRITE before TRCD elapses is ignored; READ at exactly TRCD is legal
    act(4'd1);
    bad(CMD_WRITE, '0, 12'h001, 32'h11111111);
    rd(12'h001, 32'hA5A5A5A5, "rd_early_write_ignored");

    // Reset one cycle before the data edge aborts the read
    issue(CMD_READ, '0, 12'h001, '0, 1'b0);
    nop(1);
    rst_n = 1'b0;
    nop(1);
    rst_n = 1'b1;
    check("abort_row_open", 32'(bus.row_open), 32'd0);
    check("abort_busy",     32'(bus.busy),     32'd0);
    check("abort_open_row", 32'(bus.open_row), 32'd0);
    nop(TCAS);
    check("abort_dq_oe",    32'(bus.dq_oe),    32'd0);

    // Deselected WRITE is ignored
    act(4'd1);
    nop(1);
    issue(CMD_WRITE, '0, 12'h001, 32'h12345678, 1'b1);
    rd(12'h001, 32'hA5A5A5A5, "rd_cs_n_high_write");

    // Reserved opcode and ACTIVATE while open are ignored; write then read back-to-back
    bad(3'd7, '0, '0, '0);
    bad(CMD_ACTIVATE, 4'd3, '0, '0);
    check("reopen_open_row", 32'(bus.open_row), 32'd1);
    wr(12'h002, 32'h0BADF00D);
    rd_start(12'h002, 32'h0BADF00D, "rd_write_then_read");
    // A command on the data edge is still inside the latency window
    nop(TCAS - 1);
    bad(CMD_PRECHARGE, '0, '0, '0);
    check("rdlat_pre_row_open", 32'(bus.row_open), 32'd1);
    nop(1);
    issue(CMD_PRECHARGE, '0, '0, '0, 1'b0);
    check("final_row_open", 32'(bus.row_open), 32'd0);

    nop(4);
    check("rd_queue_empty",   32'(rd_q.size()),   32'd0);
    check("prot_queue_empty", 32'(prot_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
